push_conditioner: RTL and testbench



---
 rtl/push_defs_pkg.sv | 19 +
 rtl/push_channel.sv | 90 +++++++++
 rtl/push_conditioner.sv | 36 +++
 tb/tb_push_conditioner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/push_defs_pkg.sv
// Shared definitions for the push button conditioner:
// the repeat FSM encoding and default timing for a 50 MHz clock.
package push_defs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/push_channel.sv
// One button channel: 2-flop synchronizer, debounce counter and
// hold-to-repeat FSM producing a clean active-low level plus strobes.
module push_channel
    import push_defs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic btn,
    output logic push,
    output logic pressed,
    output logic released
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] db_cnt;
    logic [TMR_W-1:0] timer;
    rep_state_t       state;

    // An accepted level change takes priority over repeat timing, so a
    // release always wins over a repeat strobe due in the same cycle.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            push     <= 1'b1;
            pressed  <= 1'b0;
            released <= 1'b0;
            db_cnt   <= '0;
            timer    <= '0;
            state    <= IDLE;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            pressed  <= 1'b0;
            released <= 1'b0;

            if (sync2 != push && db_cnt == DB_LAST) begin
                push   <= sync2;
                db_cnt <= '0;
                timer  <= '0;
                if (!sync2) begin
                    pressed <= 1'b1;
                    state   <= REPEAT_EN ? DELAY : IDLE;
                end else begin
                    released <= 1'b1;
                    state    <= IDLE;
                end
            end else begin
                db_cnt <= (sync2 != push) ? db_cnt + 1'b1 : '0;
                case (state)
                    DELAY: begin
                        if (timer == DELAY_LAST) begin
                            pressed <= 1'b1;
                            state   <= REPEAT;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (timer == RATE_LAST) begin
                            pressed <= 1'b1;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/push_conditioner.sv
// Conditions N raw active-low buttons into debounced levels and
// press/release strobes, one independent channel per button.
module push_conditioner
    import push_defs_pkg::*;
#(
    parameter int             N               = 3,
    parameter int             DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int             REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int             REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [N-1:0]   REPEAT_EN       = {N{1'b1}}
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic [N-1:0] i_Btn,
    output logic [N-1:0] o_Push,
    output logic [N-1:0] o_Pressed,
    output logic [N-1:0] o_Released
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        push_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_EN[i])
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .btn      (i_Btn[i]),
            .push     (o_Push[i]),
            .pressed  (o_Pressed[i]),
            .released (o_Released[i])
        );
    end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner: a vector table for clean and
// simultaneous presses, plus hand sequences for bounce, repeat and reset.
module tb_push_conditioner;

    logic       i_Clk;
    logic       i_Rst;
    logic [2:0] i_Btn;
    logic [2:0] o_Push;
    logic [2:0] o_Pressed;
    logic [2:0] o_Released;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] btn;
        logic [2:0] push;
        logic [2:0] pressed;
        logic [2:0] released;
    } vec_t;

    vec_t vecs[$];

    push_conditioner #(
        .N               (3),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8),
        .REPEAT_EN       (3'b011)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Btn      (i_Btn),
        .o_Push     (o_Push),
        .o_Pressed  (o_Pressed),
        .o_Released (o_Released)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] b);
        i_Btn = b;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] ep,
                               input logic [2:0] epr, input logic [2:0] erl);
        total += 3;
        if (o_Push !== ep) begin
            bad++;
            $display("[TB] FAIL %s o_Push: got %b want %b", name, o_Push, ep);
        end
        if (o_Pressed !== epr) begin
            bad++;
            $display("[TB] FAIL %s o_Pressed: got %b want %b", name, o_Pressed, epr);
        end
        if (o_Released !== erl) begin
            bad++;
            $display("[TB] FAIL %s o_Released: got %b want %b", name, o_Released, erl);
        end
    endtask

    task automatic addVec(input logic [2:0] b, input logic [2:0] p,
                          input logic [2:0] pr, input logic [2:0] rl, input int n);
        vec_t v;
        v.btn      = b;
        v.push     = p;
        v.pressed  = pr;
        v.released = rl;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] exp_pr;

        // Clean press/release on channel 0, then simultaneous press on 0 and 1.
        addVec(3'b110, 3'b111, 3'b000, 3'b000, 6);
        addVec(3'b110, 3'b110, 3'b001, 3'b000, 1);
        addVec(3'b110, 3'b110, 3'b000, 3'b000, 1);
        addVec(3'b111, 3'b110, 3'b000, 3'b000, 6);
        addVec(3'b111, 3'b111, 3'b000, 3'b001, 1);
        addVec(3'b111, 3'b111, 3'b000, 3'b000, 1);
        addVec(3'b100, 3'b111, 3'b000, 3'b000, 6);
        addVec(3'b100, 3'b100, 3'b011, 3'b000, 1);
        addVec(3'b100, 3'b100, 3'b000, 3'b000, 1);
        addVec(3'b111, 3'b100, 3'b000, 3'b000, 6);
        addVec(3'b111, 3'b111, 3'b000, 3'b011, 1);
        addVec(3'b111, 3'b111, 3'b000, 3'b000, 2);

        i_Rst = 1'b1;
        i_Btn = 3'b111;
        #1;
        checkOutput("reset_initial", 3'b111, 3'b000, 3'b000);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(3'($urandom_range(0, 7)));
            tick();
            checkOutput($sformatf("reset_hold[%0d]", c), 3'b111, 3'b000, 3'b000);
        end
        applyStimulus(3'b111);
        i_Rst = 1'b0;
        tick();
        checkOutput("post_reset_idle", 3'b111, 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].btn);
            tick();
            checkOutput($sformatf("vec[%0d]", i), vecs[i].push, vecs[i].pressed, vecs[i].released);
        end

        // Channel 1 bounces with a 4-cycle period, never stable long enough.
        for (int c = 0; c < 20; c++) begin
            applyStimulus({1'b1, ((c % 4) < 2) ? 1'b0 : 1'b1, 1'b1});
            tick();
            checkOutput($sformatf("bounce[%0d]", c), 3'b111, 3'b000, 3'b000);
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus(3'b101);
            tick();
            checkOutput($sformatf("settle[%0d]", c), (c >= 6) ? 3'b101 : 3'b111,
                        (c == 6) ? 3'b010 : 3'b000, 3'b000);
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus(3'b111);
            tick();
            checkOutput($sformatf("unsettle[%0d]", c), (c >= 6) ? 3'b111 : 3'b101,
                        3'b000, (c == 6) ? 3'b010 : 3'b000);
        end

        // Hold channels 0 (repeat enabled) and 2 (repeat disabled).
        for (int c = 0; c < 66; c++) begin
            applyStimulus(3'b010);
            tick();
            exp_pr = 3'b000;
            if (c == 6 || c == 26 || c == 34 || c == 42 || c == 50 || c == 58) exp_pr[0] = 1'b1;
            if (c == 6) exp_pr[2] = 1'b1;
            checkOutput($sformatf("hold[%0d]", c), (c >= 6) ? 3'b010 : 3'b111, exp_pr, 3'b000);
        end

        // Asynchronous reset mid-cycle while channel 0 is repeating.
        i_Rst = 1'b1;
        #1;
        checkOutput("rst_async", 3'b111, 3'b000, 3'b000);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("rst_mid[%0d]", c), 3'b111, 3'b000, 3'b000);
        end
        i_Rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput($sformatf("after_rst[%0d]", c), (c >= 6) ? 3'b010 : 3'b111,
                        (c == 6) ? 3'b101 : 3'b000, 3'b000);
        end

        for (int c = 0; c < 8; c++) begin
            applyStimulus(3'b111);
            tick();
            checkOutput($sformatf("final_release[%0d]", c), (c >= 6) ? 3'b111 : 3'b010,
                        3'b000, (c == 6) ? 3'b101 : 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
